alu_share_arbiter: RTL and testbench

- Shares one combinational ALU (5-bit func = {compare, iword[7:4]}, two signed operands, dataOut plus compTrue) among NUM_REQ requesters.
- Requesters are, for example, the main execute path, the branch unit and the address generator.
- Grants one request at a time by round-robin and drives the ALU from registered operands.
- Returns a registered result on a single tagged response channel with a valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU among NUM_REQ requesters, one transaction at a time.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 first) instead of round-robin.
module alu_share_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [5*NUM_REQ-1:0]         req_func,
    input  logic [BIT_WIDTH*NUM_REQ-1:0] req_a,
    input  logic [BIT_WIDTH*NUM_REQ-1:0] req_b,
    output logic [4:0]                   alu_func,
    output logic [BIT_WIDTH-1:0]         alu_in1,
    output logic [BIT_WIDTH-1:0]         alu_in2,
    input  logic [BIT_WIDTH-1:0]         alu_out,
    input  logic                         alu_comp,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [BIT_WIDTH-1:0]         rsp_data,
    output logic                         rsp_comp,
    output logic [1:0]                   dbgState
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]           state;
    logic [4:0]           opFunc;
    logic [BIT_WIDTH-1:0] opA;
    logic [BIT_WIDTH-1:0] opB;
    logic                 grantFound;
    logic [ID_W-1:0]      grantIdx;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grantFound && req_valid[k]) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0]      rrPtr;
    logic [2*NUM_REQ-1:0] dblValid;
    logic [NUM_REQ-1:0]   rotValid;
    int                   scanIdx;

    // Rotate the valid vector so bit 0 is the requester rrPtr points at.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        scanIdx    = 0;
        dblValid   = {req_valid, req_valid} >> rrPtr;
        rotValid   = dblValid[NUM_REQ-1:0];
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grantFound && rotValid[k]) begin
                grantFound = 1'b1;
                scanIdx    = int'(rrPtr) + k;
                if (scanIdx >= NUM_REQ) scanIdx = scanIdx - NUM_REQ;
                grantIdx   = ID_W'(scanIdx);
            end
        end
    end
`endif

    // Handshakes: a request transfers on req_valid[i] & req_ready[i]; req_ready is one-hot and only
    // raised in IDLE. A response transfers on rsp_valid & rsp_ready; fields hold while rsp_valid waits.
    always_comb begin
        req_ready = '0;
        if (reset_n && state == IDLE && grantFound) req_ready = NUM_REQ'(1) << grantIdx;
    end

    assign rsp_valid = (state == RESP);
    assign alu_func  = opFunc;
    assign alu_in1   = opA;
    assign alu_in2   = opB;
    assign dbgState  = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            opFunc   <= '0;
            opA      <= '0;
            opB      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_comp <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rrPtr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grantFound) begin
                        opFunc <= req_func[5*int'(grantIdx) +: 5];
                        opA    <= req_a[BIT_WIDTH*int'(grantIdx) +: BIT_WIDTH];
                        opB    <= req_b[BIT_WIDTH*int'(grantIdx) +: BIT_WIDTH];
                        rsp_id <= grantIdx;
                        state  <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        rrPtr  <= (int'(grantIdx) == NUM_REQ-1) ? '0 : grantIdx + 1'b1;
`endif
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    rsp_comp <= alu_comp;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a
// transaction-level reference model; a small stand-in ALU sits on the alu_* ports.
module tb_alu_share_arbiter;
    localparam int BW = 32;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int RW = IW + 1 + BW;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [5*NR-1:0]   req_func = '0;
    logic [BW*NR-1:0]  req_a = '0;
    logic [BW*NR-1:0]  req_b = '0;
    logic [4:0]        alu_func;
    logic [BW-1:0]     alu_in1;
    logic [BW-1:0]     alu_in2;
    logic [BW-1:0]     alu_out;
    logic              alu_comp;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [BW-1:0]     rsp_data;
    logic              rsp_comp;
    logic [1:0]        dbgState;

    logic [RW-1:0]     exp_q[$];
    int                dutLog[$];
    int                errCount = 0;
    int                checkCount = 0;
    int                mPhase = 0;
    int                mPtr = 0;
    logic [4:0]        mFunc = '0;
    logic [BW-1:0]     mA = '0;
    logic [BW-1:0]     mB = '0;
    logic [NR-1:0]     lastGnt = '0;
    bit                autoReload = 0;
    bit                randMode = 0;

    alu_share_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_a(req_a), .req_b(req_b),
        .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .alu_comp(alu_comp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_comp(rsp_comp),
        .dbgState(dbgState)
    );

    // ---------------- clock / reset / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stand-in ALU: {compTrue, dataOut} from func and operands.
    function automatic logic [BW:0] aluRef(input logic [4:0] f, input logic [BW-1:0] a,
                                           input logic [BW-1:0] b);
        logic c;
        logic [BW-1:0] d;
        c = 1'b0;
        d = '0;
        if (!f[4]) begin
            case (f[1:0])
                2'd0: d = a + b;
                2'd1: d = a - b;
                2'd2: d = a & b;
                default: d = a ^ b;
            endcase
        end else begin
            case (f[1:0])
                2'd0: c = (a == b);
                2'd1: c = (a != b);
                2'd2: c = ($signed(a) < $signed(b));
                default: c = (a < b);
            endcase
            d = {{(BW-1){1'b0}}, c};
        end
        return {c, d};
    endfunction

    always_comb {alu_comp, alu_out} = aluRef(alu_func, alu_in1, alu_in2);

    // ---------------- checking ----------------
    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model step, evaluated at the falling edge with inputs stable for the next rise.
    task automatic monitorStep();
        logic [NR-1:0] expReady;
        logic [BW:0]   res;
        int g;
        int idx;
        expReady = '0;
        g = -1;
        if (mPhase == 0 && reset_n) begin
            for (int k = 0; k < NR; k++) begin
                idx = (mPtr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) expReady[g] = 1'b1;
        end
        checkEq("req_ready", 64'(req_ready), 64'(expReady));
        checkEq("rsp_valid", 64'(rsp_valid), 64'(mPhase == 2));
        if (mPhase == 1) begin
            checkEq("alu_func", 64'(alu_func), 64'(mFunc));
            checkEq("alu_in1", 64'(alu_in1), 64'(mA));
            checkEq("alu_in2", 64'(alu_in2), 64'(mB));
        end
        if (mPhase == 2 && exp_q.size() > 0) begin
            checkEq("rsp_id", 64'(rsp_id), 64'(exp_q[0][RW-1 -: IW]));
            checkEq("rsp_comp", 64'(rsp_comp), 64'(exp_q[0][BW]));
            checkEq("rsp_data", 64'(rsp_data), 64'(exp_q[0][BW-1:0]));
        end
        if (!reset_n) begin
            mPhase = 0;
            mPtr = 0;
            exp_q.delete();
        end else if (mPhase == 0) begin
            if (g >= 0) begin
                mFunc = req_func[g*5 +: 5];
                mA = req_a[g*BW +: BW];
                mB = req_b[g*BW +: BW];
                res = aluRef(mFunc, mA, mB);
                exp_q.push_back({IW'(g), res});
`ifdef ALU_ARB_FIXED_PRIO_EN
                mPtr = 0;
`else
                mPtr = (g + 1) % NR;
`endif
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            mPhase = 2;
        end else if (rsp_ready) begin
            void'(exp_q.pop_front());
            mPhase = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic setReq(input int i, input logic [4:0] f, input logic [BW-1:0] a,
                          input logic [BW-1:0] b);
        req_valid[i] = 1'b1;
        req_func[i*5 +: 5] = f;
        req_a[i*BW +: BW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    task automatic loadRandom(input int i);
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        a = ($urandom_range(3) == 0) ? BW'($urandom_range(20)) - 10 : BW'($urandom);
        b = ($urandom_range(3) == 0) ? a : BW'($urandom);
        setReq(i, 5'($urandom_range(31)), a, b);
    endtask

    // One clock: model check at the falling edge, then requester updates just after the rise.
    task automatic tick();
        logic [NR-1:0] gm;
        @(negedge clk);
        monitorStep();
        gm = req_ready;
        lastGnt = gm;
        for (int k = 0; k < NR; k++) if (gm[k]) dutLog.push_back(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (gm[k]) begin
                if (autoReload) loadRandom(k);
                else req_valid[k] = 1'b0;
            end else if (randMode) begin
                if (!req_valid[k] && $urandom_range(99) < 30) loadRandom(k);
                else if (req_valid[k] && $urandom_range(99) < 5) req_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int expOrd[5];
        int base;
        bit seen;
        logic [BW-1:0] heldData;
        logic [IW-1:0] heldId;

`ifdef ALU_ARB_FIXED_PRIO_EN
        expOrd = '{0, 0, 0, 0, 0};
`else
        expOrd = '{0, 1, 2, 3, 0};
`endif
        @(posedge clk);
        #1;
        doReset();
        checkEq("rst_req_ready", 64'(req_ready), 64'd0);
        checkEq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkEq("rst_rsp_id", 64'(rsp_id), 64'd0);
        checkEq("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkEq("rst_rsp_comp", 64'(rsp_comp), 64'd0);
        checkEq("rst_alu_func", 64'(alu_func), 64'd0);
        checkEq("rst_alu_in1", 64'(alu_in1), 64'd0);
        checkEq("rst_alu_in2", 64'(alu_in2), 64'd0);

        // Single add on requester 0.
        rsp_ready = 1'b1;
        setReq(0, 5'b00000, 32'd7, 32'd5);
        tick();
        checkEq("t1_grant", 64'(lastGnt), 64'b0001);
        tick();
        checkEq("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        checkEq("t1_rsp_id", 64'(rsp_id), 64'd0);
        checkEq("t1_rsp_data", 64'(rsp_data), 64'd12);
        checkEq("t1_rsp_comp", 64'(rsp_comp), 64'd0);
        tick();
        checkEq("t1_idle_valid", 64'(rsp_valid), 64'd0);
        checkEq("t1_idle_ready", 64'(req_ready), 64'd0);

        // All requesters continuously valid: grant order.
        doReset();
        dutLog.delete();
        autoReload = 1;
        for (int k = 0; k < NR; k++) loadRandom(k);
        ticks(15);
        autoReload = 0;
        req_valid = '0;
        ticks(4);
        checkEq("order_count", 64'(dutLog.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            if (i < dutLog.size()) checkEq($sformatf("order_%0d", i), 64'(dutLog[i]), 64'(expOrd[i]));

        // Signed less-than on requester 2.
        setReq(2, 5'b10010, 32'hFFFF_FFFD, 32'd1);
        tick();
        tick();
        checkEq("t3_rsp_id", 64'(rsp_id), 64'd2);
        checkEq("t3_rsp_data", 64'(rsp_data), 64'd1);
        checkEq("t3_rsp_comp", 64'(rsp_comp), 64'd1);
        tick();

        // Backpressure with requester 1 pending.
        rsp_ready = 1'b0;
        setReq(0, 5'b00001, 32'd50, 32'd8);
        tick();
        setReq(1, 5'b00011, 32'h0F0F_0F0F, 32'h00FF_00FF);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (rsp_valid) seen = 1;
            else tick();
        end
        checkEq("bp_wait", 64'(seen), 64'd1);
        heldData = rsp_data;
        heldId = rsp_id;
        ticks(5);
        checkEq("bp_hold_valid", 64'(rsp_valid), 64'd1);
        checkEq("bp_hold_data", 64'(rsp_data), 64'(heldData));
        checkEq("bp_hold_id", 64'(rsp_id), 64'(heldId));
        checkEq("bp_hold_data_val", 64'(rsp_data), 64'd42);
        checkEq("bp_ready_low", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        tick();
        checkEq("bp_idle_grant", 64'(req_ready), 64'b0010);
        ticks(3);

        // Reset while in EXEC discards the transaction.
        setReq(0, 5'b00000, 32'd1, 32'd2);
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkEq("rx_rsp_valid", 64'(rsp_valid), 64'd0);
        ticks(3);
        checkEq("rx_no_rsp", 64'(rsp_valid), 64'd0);
        setReq(0, 5'b00000, 32'd3, 32'd4);
        setReq(3, 5'b00000, 32'd5, 32'd6);
        base = dutLog.size();
        tick();
        checkEq("rx_grant_cnt", 64'(dutLog.size()), 64'(base + 1));
        checkEq("rx_grant", 64'(lastGnt), 64'b0001);
        ticks(5);
        req_valid = '0;
        ticks(4);

        // Operands captured at grant stay on the ALU during EXEC.
        setReq(1, 5'b00000, 32'd100, 32'd23);
        tick();
        req_a[1*BW +: BW] = 32'd999;
        req_b[1*BW +: BW] = 32'd1;
        tick();
        checkEq("stab_rsp_data", 64'(rsp_data), 64'd123);
        tick();

        // Randomized traffic with random response backpressure.
        randMode = 1;
        for (int i = 0; i < 600; i++) begin
            rsp_ready = ($urandom_range(3) != 0);
            tick();
        end
        randMode = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        ticks(6);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
